// File: rtl/lms_fir_csa_if.sv
// Handshake and weight-load bundle for lms_fir_csa.
// The master side drives samples and weight loads; the slave side is the filter.
interface lms_fir_csa_if #(
  parameter int unsigned TAPS = 8,
  parameter int unsigned XW   = 10,
  parameter int unsigned WW   = 10,
  parameter int unsigned ACCW = XW + WW + $clog2(TAPS)
);
  localparam int unsigned IdxW = $clog2(TAPS);

  logic            in_valid;
  logic            in_ready;
  logic [XW-1:0]   x_in;
  logic [ACCW-1:0] d_in;
  logic            adapt_en;
  logic            out_valid;
  logic            out_ready;
  logic [ACCW-1:0] y_out;
  logic [ACCW-1:0] e_out;
  logic            w_load;
  logic [IdxW-1:0] w_load_idx;
  logic [WW-1:0]   w_load_data;
  logic            busy;

  modport master (
    output in_valid, x_in, d_in, adapt_en, out_ready, w_load, w_load_idx, w_load_data,
    input  in_ready, out_valid, y_out, e_out, busy
  );

  modport slave (
    input  in_valid, x_in, d_in, adapt_en, out_ready, w_load, w_load_idx, w_load_data,
    output in_ready, out_valid, y_out, e_out, busy
  );
endinterface

// File: rtl/lms_fir_csa.sv
// Adaptive LMS FIR: one tap per cycle into a carry-save accumulator, a single carry-propagate
// resolve, then an optional one-tap-per-cycle sign-aware weight update.
module lms_fir_csa #(
  parameter int unsigned TAPS     = 8,
  parameter int unsigned XW       = 10,
  parameter int unsigned WW       = 10,
  parameter int unsigned ACCW     = XW + WW + $clog2(TAPS),
  parameter int unsigned MU_SHIFT = 4
) (
  input logic          clk,
  input logic          rst_n,
  lms_fir_csa_if.slave bus_io
);
  localparam int unsigned IdxW = $clog2(TAPS);
  localparam int unsigned PW   = XW + WW;
  localparam int unsigned UW   = ACCW + XW;
  localparam logic [IdxW-1:0] LastK = IdxW'(TAPS - 1);

  typedef enum logic [2:0] {StIdle, StMac, StResolve, StOut, StUpdate} state_e;

  state_e          state_q, state_d;
  logic [IdxW-1:0] k_q, k_d;
  logic [XW-1:0]   x_q [TAPS];
  logic [XW-1:0]   x_d [TAPS];
  logic [WW-1:0]   w_q [TAPS];
  logic [WW-1:0]   w_d [TAPS];
  logic [ACCW-1:0] s_q, s_d, c_q, c_d;
  logic [ACCW-1:0] d_q, d_d, y_q, y_d, e_q, e_d;
  logic            adapt_q, adapt_d;
  logic            out_valid_q, out_valid_d;

  logic [XW-1:0]   x_cur;
  logic [WW-1:0]   w_cur;
  logic [PW-1:0]   mac_prod;
  logic [ACCW-1:0] p_ext, csa_sum, csa_maj, csa_carry;
  logic [ACCW:0]   diff;
  logic [ACCW-1:0] e_sat;
  logic signed [UW-1:0] upd_prod, upd_step;
  logic [UW:0]     w_sum;
  logic            w_ovf;
  logic [WW-1:0]   w_sat;

  assign x_cur = x_q[k_q];
  assign w_cur = w_q[k_q];

  // Operands sign-extended to the product width, so the low PW bits are the signed product.
  assign mac_prod = {{WW{x_cur[XW-1]}}, x_cur} * {{XW{w_cur[WW-1]}}, w_cur};
  assign p_ext    = {{(ACCW - PW){mac_prod[PW-1]}}, mac_prod};

  assign csa_sum   = s_q ^ c_q ^ p_ext;
  assign csa_maj   = (s_q & c_q) | (s_q & p_ext) | (c_q & p_ext);
  assign csa_carry = csa_maj << 1;

  assign diff  = {d_q[ACCW-1], d_q} - {y_q[ACCW-1], y_q};
  assign e_sat = (diff[ACCW] != diff[ACCW-1]) ? {diff[ACCW], {(ACCW - 1){~diff[ACCW]}}}
                                              : diff[ACCW-1:0];

  assign upd_prod = {{XW{e_q[ACCW-1]}}, e_q} * {{ACCW{x_cur[XW-1]}}, x_cur};
  assign upd_step = upd_prod >>> MU_SHIFT;
  assign w_sum    = {{(UW + 1 - WW){w_cur[WW-1]}}, w_cur} + {upd_step[UW-1], upd_step};
  assign w_ovf    = w_sum[UW:WW-1] != {(UW - WW + 2){w_sum[UW]}};
  assign w_sat    = w_ovf ? {w_sum[UW], {(WW - 1){~w_sum[UW]}}} : w_sum[WW-1:0];

  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    x_d         = x_q;
    w_d         = w_q;
    s_d         = s_q;
    c_d         = c_q;
    d_d         = d_q;
    y_d         = y_q;
    e_d         = e_q;
    adapt_d     = adapt_q;
    out_valid_d = out_valid_q;

    case (state_q)
      StIdle: begin
        if (bus_io.w_load) begin
          w_d[bus_io.w_load_idx] = bus_io.w_load_data;
        end else if (bus_io.in_valid) begin
          x_d[0] = bus_io.x_in;
          for (int i = 1; i < TAPS; i++) begin
            x_d[i] = x_q[i-1];
          end
          d_d     = bus_io.d_in;
          adapt_d = bus_io.adapt_en;
          s_d     = '0;
          c_d     = '0;
          k_d     = '0;
          state_d = StMac;
        end
      end
      StMac: begin
        s_d = csa_sum;
        c_d = csa_carry;
        if (k_q == LastK) begin
          state_d = StResolve;
        end else begin
          k_d = k_q + IdxW'(1);
        end
      end
      StResolve: begin
        y_d     = s_q + c_q;
        state_d = StOut;
      end
      StOut: begin
        // First OUT cycle forms the saturated error from the registered y.
        if (!out_valid_q) begin
          e_d         = e_sat;
          out_valid_d = 1'b1;
        end else if (bus_io.out_ready) begin
          out_valid_d = 1'b0;
          k_d         = '0;
          state_d     = adapt_q ? StUpdate : StIdle;
        end
      end
      StUpdate: begin
        w_d[k_q] = w_sat;
        if (k_q == LastK) begin
          state_d = StIdle;
        end else begin
          k_d = k_q + IdxW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      k_q         <= '0;
      x_q         <= '{default: '0};
      w_q         <= '{default: '0};
      s_q         <= '0;
      c_q         <= '0;
      d_q         <= '0;
      y_q         <= '0;
      e_q         <= '0;
      adapt_q     <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      x_q         <= x_d;
      w_q         <= w_d;
      s_q         <= s_d;
      c_q         <= c_d;
      d_q         <= d_d;
      y_q         <= y_d;
      e_q         <= e_d;
      adapt_q     <= adapt_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus_io.in_ready  = (state_q == StIdle) & ~bus_io.w_load;
  assign bus_io.out_valid = out_valid_q;
  assign bus_io.y_out     = y_q;
  assign bus_io.e_out     = e_q;
  assign bus_io.busy      = (state_q != StIdle);
endmodule

// File: tb/tb_lms_fir_csa.sv
// Bench for lms_fir_csa: an arithmetic LMS model checked every cycle, plus directed
// scenarios pinned with hand-computed results and a randomized run.
module tb_lms_fir_csa;
  localparam int unsigned TAPS     = 8;
  localparam int unsigned XW       = 10;
  localparam int unsigned WW       = 10;
  localparam int unsigned ACCW     = 23;
  localparam int unsigned MU_SHIFT = 4;
  localparam int unsigned IdxW     = $clog2(TAPS);
  localparam int EMAX = (1 << (ACCW - 1)) - 1;
  localparam int EMIN = -(1 << (ACCW - 1));
  localparam int BIG  = 32'h3fff_ffff;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   cyc      = 0;
  int   n_checks = 0;
  int   n_pass   = 0;

  lms_fir_csa_if #(.TAPS(TAPS), .XW(XW), .WW(WW), .ACCW(ACCW)) bus ();

  lms_fir_csa #(
    .TAPS(TAPS), .XW(XW), .WW(WW), .ACCW(ACCW), .MU_SHIFT(MU_SHIFT)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus_io(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(string name, longint act, longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endfunction

  function automatic longint clamp(longint v, longint lo, longint hi);
    return (v < lo) ? lo : ((v > hi) ? hi : v);
  endfunction

  // Reference model: plain integer weights, delay line and a transaction timeline.
  int w_m [TAPS];
  int x_m [TAPS];
  int y_m, e_m;
  bit active, adapt_m, exp_busy, exp_valid;
  int acc_edge, hs_edge, end_edge;

  function automatic void model_reset();
    for (int k = 0; k < TAPS; k++) begin
      w_m[k] = 0;
      x_m[k] = 0;
    end
    active = 1'b0;
  endfunction

  always @(negedge clk) begin
    if (!rst_n) begin
      model_reset();
      chk("rst_out_valid", bus.out_valid, 0);
      chk("rst_busy", bus.busy, 0);
    end else begin
      if (active && cyc >= end_edge) active = 1'b0;
      exp_busy  = active;
      exp_valid = active && (cyc >= acc_edge + int'(TAPS) + 2) && (cyc < hs_edge);
      chk("out_valid", bus.out_valid, exp_valid);
      chk("busy", bus.busy, exp_busy);
      chk("in_ready", bus.in_ready, !exp_busy && !bus.w_load);
      if (exp_valid) begin
        chk("y_out", int'($signed(bus.y_out)), y_m);
        chk("e_out", int'($signed(bus.e_out)), e_m);
      end
      if (!exp_busy) begin
        if (bus.w_load) begin
          w_m[bus.w_load_idx] = int'($signed(bus.w_load_data));
        end else if (bus.in_valid) begin
          for (int k = TAPS - 1; k > 0; k--) x_m[k] = x_m[k-1];
          x_m[0] = int'($signed(bus.x_in));
          y_m = 0;
          for (int k = 0; k < TAPS; k++) y_m += w_m[k] * x_m[k];
          e_m      = int'(clamp(longint'(int'($signed(bus.d_in))) - y_m, EMIN, EMAX));
          adapt_m  = bus.adapt_en;
          active   = 1'b1;
          acc_edge = cyc + 1;
          hs_edge  = BIG;
          end_edge = BIG;
        end
      end else if (exp_valid && bus.out_ready) begin
        hs_edge  = cyc + 1;
        end_edge = hs_edge + (adapt_m ? int'(TAPS) : 0);
        if (adapt_m) begin
          for (int k = 0; k < TAPS; k++) begin
            w_m[k] = int'(clamp(longint'(w_m[k]) + ((longint'(e_m) * x_m[k]) >>> MU_SHIFT),
                                -512, 511));
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic load_w(input int idx, input int val);
    bus.w_load      = 1'b1;
    bus.w_load_idx  = IdxW'(idx);
    bus.w_load_data = WW'(val);
    step();
    bus.w_load = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (bus.busy && n < 100) begin
      step();
      n++;
    end
    chk("idle_timeout", bus.busy, 0);
  endtask

  task automatic start(input int x, input int d, input bit adapt);
    wait_idle();
    bus.in_valid = 1'b1;
    bus.x_in     = XW'(x);
    bus.d_in     = ACCW'(d);
    bus.adapt_en = adapt;
    step();
    bus.in_valid = 1'b0;
  endtask

  task automatic finish(input int stall, output int y, output int e, output int lat);
    lat = 0;
    while (!bus.out_valid && lat < 50) begin
      step();
      lat++;
    end
    chk("out_valid_timeout", bus.out_valid, 1);
    repeat (stall) step();
    y = int'($signed(bus.y_out));
    e = int'($signed(bus.e_out));
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    wait_idle();
  endtask

  task automatic txn(input int x, input int d, input bit adapt, input int stall,
                     output int y, output int e);
    int lat;
    start(x, d, adapt);
    finish(stall, y, e, lat);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    int y, e, lat;
    bus.in_valid    = 1'b0;
    bus.x_in        = '0;
    bus.d_in        = '0;
    bus.adapt_en    = 1'b0;
    bus.out_ready   = 1'b0;
    bus.w_load      = 1'b0;
    bus.w_load_idx  = '0;
    bus.w_load_data = '0;
    do_reset();
    chk("reset_y_out", int'($signed(bus.y_out)), 0);
    chk("reset_e_out", int'($signed(bus.e_out)), 0);
    chk("reset_in_ready", bus.in_ready, 1);

    // Impulse through w = 1..8 walks the weights out one per sample.
    for (int k = 0; k < TAPS; k++) load_w(k, k + 1);
    for (int i = 0; i < TAPS; i++) begin
      start((i == 0) ? 1 : 0, 100, 1'b0);
      finish(0, y, e, lat);
      chk("t1_y", y, i + 1);
      chk("t1_e", e, 100 - (i + 1));
      chk("t1_latency", lat, 10);
    end

    // Full negative range: -512 * -512 summed eight times, error saturates low.
    do_reset();
    for (int k = 0; k < TAPS; k++) load_w(k, -512);
    for (int i = 0; i < TAPS; i++) begin
      txn(-512, -4194304, 1'b0, 0, y, e);
      chk("t2_y", y, (i + 1) * 262144);
      chk("t2_e_sat", e, -4194304);
    end

    // Large positive error drives w[0] to its upper clamp; w[1] sees x=0 and stays 0.
    do_reset();
    txn(64, 4096, 1'b1, 0, y, e);
    chk("t3_y", y, 0);
    chk("t3_e", e, 4096);
    txn(64, 0, 1'b0, 0, y, e);
    chk("t3_y_after", y, 32704);
    chk("t3_e_after", e, -32704);

    // Negative step floors: (-1*3) >>> 4 = -1.
    do_reset();
    txn(3, -1, 1'b1, 0, y, e);
    chk("floor_e", e, -1);
    txn(1, 0, 1'b0, 0, y, e);
    chk("floor_y", y, -1);

    // Output stall for five cycles with adapt pending.
    do_reset();
    load_w(0, 2);
    txn(10, 1000, 1'b1, 5, y, e);
    chk("t4_y", y, 20);
    chk("t4_e", e, 980);
    txn(1, 0, 1'b0, 0, y, e);
    chk("t4_y_after", y, 511);

    // Reset in MAC cycle 3 discards the work and clears the weights.
    for (int k = 0; k < TAPS; k++) load_w(k, k + 1);
    start(7, 0, 1'b0);
    step();
    step();
    step();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    repeat (15) step();
    chk("t5_busy", bus.busy, 0);
    chk("t5_in_ready", bus.in_ready, 1);
    txn(100, 0, 1'b0, 0, y, e);
    chk("t5_y_zero_w", y, 0);

    // Weight load during MAC is dropped; load beside in_valid in IDLE wins over the sample.
    start(20, 0, 1'b0);
    load_w(0, 7);
    finish(0, y, e, lat);
    chk("t6_y_mac_load", y, 0);
    wait_idle();
    bus.in_valid = 1'b1;
    bus.x_in     = XW'(33);
    load_w(1, 3);
    bus.in_valid = 1'b0;
    chk("t6_no_accept", bus.busy, 0);
    txn(5, 0, 1'b0, 0, y, e);
    chk("t6_y", y, 60);

    // Randomized traffic against the model.
    do_reset();
    for (int k = 0; k < TAPS; k++) load_w(k, int'($urandom_range(0, 1023)) - 512);
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 3) == 0)
        load_w(int'($urandom_range(0, TAPS - 1)), int'($urandom_range(0, 1023)) - 512);
      txn(int'($urandom_range(0, 1023)) - 512,
          int'($urandom_range(0, (1 << ACCW) - 1)) - (1 << (ACCW - 1)),
          1'($urandom_range(0, 1)), int'($urandom_range(0, 3)), y, e);
    end
    repeat (3) step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
